// File: rtl/axis_packet_source_if.sv
// ----------------------------------------------------------------------------
// axis_packet_source_if
//   AXI-Stream link carried from the packet source to a downstream slave.
//
//   Parameters
//     DATA_W    width of m_tdata
//
//   Signals
//     m_tvalid  master -> slave  beat valid
//     m_tdata   master -> slave  beat payload
//     m_tlast   master -> slave  final beat of the packet
//     m_tready  slave -> master  downstream can accept the beat
//
//   Modports
//     master    used by axis_packet_source
//     slave     used by the consumer of the stream
// ----------------------------------------------------------------------------
interface axis_packet_source_if #(
    parameter int DATA_W = 8
) ();
    logic              m_tvalid;
    logic [DATA_W-1:0] m_tdata;
    logic              m_tlast;
    logic              m_tready;

    modport master (
        output m_tvalid,
        output m_tdata,
        output m_tlast,
        input  m_tready
    );

    modport slave (
        input  m_tvalid,
        input  m_tdata,
        input  m_tlast,
        output m_tready
    );
endinterface

// File: rtl/axis_packet_source.sv
// ----------------------------------------------------------------------------
// axis_packet_source
//   AXI-Stream master packet generator. A start request in IDLE launches one
//   packet of pkt_len beats carrying an incrementing data count (the count
//   carries on across packets and wraps at 2**DATA_W). m_tlast marks the
//   final beat. Backpressure through m_tready is fully honoured. After each
//   packet an optional idle gap of GAP_CYCLES cycles is inserted before a
//   new start can be accepted.
//
//   Parameters
//     DATA_W      width of m_tdata and of the data counter
//     LEN_W       width of pkt_len (max packet 2**LEN_W-1 beats)
//     GAP_CYCLES  idle cycles after each packet (0 = straight back to IDLE)
//
//   Ports
//     clk        clock, all logic on the rising edge
//     rst        asynchronous active-low reset
//     start      packet request, sampled only in IDLE
//     pkt_len    packet length in beats, latched with an accepted start
//     busy       high from the cycle after an accepted start to end of gap
//     done       one-cycle pulse in the cycle after the last-beat handshake
//     m_axis     AXI-Stream master (m_tvalid/m_tdata/m_tlast out, m_tready in)
//     pkt_count  completed-packet counter, present only when the macro
//                AXIS_SRC_PKT_CNT_EN is defined
//
//   Build option
//     AXIS_SRC_PKT_CNT_EN  adds the 16-bit pkt_count output and its counter
// ----------------------------------------------------------------------------
module axis_packet_source #(
    parameter int DATA_W     = 8,
    parameter int LEN_W      = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [LEN_W-1:0]     pkt_len,
    output logic                 busy,
    output logic                 done,
    axis_packet_source_if.master m_axis
`ifdef AXIS_SRC_PKT_CNT_EN
    ,
    output logic [15:0]          pkt_count
`endif
);

    // Gap counter only has to reach GAP_CYCLES-1; keep it at least one bit
    // wide so the declaration stays legal when the gap is disabled.
    localparam int GAP_W = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t             state_reg,  state_next;
    logic [LEN_W-1:0]   len_reg,    len_next;
    logic [LEN_W-1:0]   beat_reg,   beat_next;
    logic [DATA_W-1:0]  data_reg,   data_next;
    logic [GAP_W-1:0]   gap_reg,    gap_next;
    logic               tvalid_reg, tvalid_next;
    logic               tlast_reg,  tlast_next;
    logic               busy_reg,   busy_next;
    logic               done_reg,   done_next;
`ifdef AXIS_SRC_PKT_CNT_EN
    logic [15:0]        cnt_reg,    cnt_next;
`endif

    logic               handshake;
    logic [LEN_W-1:0]   len_m1;
    logic [LEN_W-1:0]   beat_inc;

    assign handshake = tvalid_reg && m_axis.m_tready;
    assign len_m1    = len_reg - 1'b1;
    assign beat_inc  = beat_reg + 1'b1;

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= IDLE;
            len_reg    <= '0;
            beat_reg   <= '0;
            data_reg   <= '0;
            gap_reg    <= '0;
            tvalid_reg <= 1'b0;
            tlast_reg  <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
`ifdef AXIS_SRC_PKT_CNT_EN
            cnt_reg    <= '0;
`endif
        end else begin
            state_reg  <= state_next;
            len_reg    <= len_next;
            beat_reg   <= beat_next;
            data_reg   <= data_next;
            gap_reg    <= gap_next;
            tvalid_reg <= tvalid_next;
            tlast_reg  <= tlast_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
`ifdef AXIS_SRC_PKT_CNT_EN
            cnt_reg    <= cnt_next;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next  = state_reg;
        len_next    = len_reg;
        beat_next   = beat_reg;
        data_next   = data_reg;
        gap_next    = gap_reg;
        tvalid_next = tvalid_reg;
        tlast_next  = tlast_reg;
        busy_next   = busy_reg;
        done_next   = 1'b0;
`ifdef AXIS_SRC_PKT_CNT_EN
        cnt_next    = cnt_reg;
`endif

        case (state_reg)
            IDLE: begin
                // A zero-length request is dropped without any side effect.
                if (start && (pkt_len != '0)) begin
                    state_next  = SEND;
                    len_next    = pkt_len;
                    beat_next   = '0;
                    tvalid_next = 1'b1;
                    tlast_next  = (pkt_len == LEN_W'(1));
                    busy_next   = 1'b1;
                end
            end

            SEND: begin
                // Without a handshake every output simply holds its value.
                if (handshake) begin
                    data_next = data_reg + 1'b1;
                    if (tlast_reg) begin
                        tvalid_next = 1'b0;
                        tlast_next  = 1'b0;
                        done_next   = 1'b1;
`ifdef AXIS_SRC_PKT_CNT_EN
                        cnt_next    = cnt_reg + 16'd1;
`endif
                        if (GAP_CYCLES > 0) begin
                            state_next = GAP;
                            gap_next   = '0;
                        end else begin
                            state_next = IDLE;
                            busy_next  = 1'b0;
                        end
                    end else begin
                        beat_next  = beat_inc;
                        // Registered tlast: raise it for the beat that follows.
                        tlast_next = (beat_inc == len_m1);
                    end
                end
            end

            GAP: begin
                if (gap_reg == GAP_LAST) begin
                    state_next = IDLE;
                    busy_next  = 1'b0;
                end else begin
                    gap_next = gap_reg + 1'b1;
                end
            end

            default: begin
                state_next  = IDLE;
                tvalid_next = 1'b0;
                tlast_next  = 1'b0;
                busy_next   = 1'b0;
            end
        endcase
    end

    assign m_axis.m_tvalid = tvalid_reg;
    assign m_axis.m_tdata  = data_reg;
    assign m_axis.m_tlast  = tlast_reg;
    assign busy            = busy_reg;
    assign done            = done_reg;
`ifdef AXIS_SRC_PKT_CNT_EN
    assign pkt_count       = cnt_reg;
`endif

endmodule

// File: tb/tb_axis_packet_source.sv
// ----------------------------------------------------------------------------
// tb_axis_packet_source
//   Directed self-checking bench for axis_packet_source (DATA_W=8, LEN_W=8,
//   GAP_CYCLES=2). Inputs change 1 ns after a rising edge and outputs are
//   sampled at that same point, well clear of the active edge.
//   Define AXIS_SRC_PKT_CNT_EN for both DUT and bench to cover pkt_count.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_axis_packet_source;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] pkt_len;
    logic       busy;
    logic       done;
`ifdef AXIS_SRC_PKT_CNT_EN
    logic [15:0] pkt_count;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] exp_data;

    axis_packet_source_if #(.DATA_W(8)) axis ();

    axis_packet_source #(
        .DATA_W    (8),
        .LEN_W     (8),
        .GAP_CYCLES(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .pkt_len  (pkt_len),
        .busy     (busy),
        .done     (done),
        .m_axis   (axis)
`ifdef AXIS_SRC_PKT_CNT_EN
        ,
        .pkt_count(pkt_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b0; start = 1'b0; pkt_len = 8'd0; axis.m_tready = 1'b0;
        #3;
        n_checks++;
        if ({axis.m_tvalid, axis.m_tdata, axis.m_tlast, busy, done} !== 12'h000)
            $display("FAIL reset_outputs: got v=%b d=%0d l=%b busy=%b done=%b, expected all 0",
                     axis.m_tvalid, axis.m_tdata, axis.m_tlast, busy, done);
        else n_pass++;
        step(); step();
`ifdef AXIS_SRC_PKT_CNT_EN
        n_checks++;
        if (pkt_count !== 16'd0)
            $display("FAIL reset_pkt_count: got %0d expected 0", pkt_count);
        else n_pass++;
`endif
        rst = 1'b1;
        step();
        n_checks++;
        if ({axis.m_tvalid, busy, done} !== 3'b000)
            $display("FAIL reset_release_idle: got v=%b busy=%b done=%b expected 0 0 0",
                     axis.m_tvalid, busy, done);
        else n_pass++;
        exp_data = 8'd0;
        $display("reset released");
    endtask

    // ------------------------------------------------------------------
    // Finish checks shared by every full packet: done pulse, then the gap.
    // Written out per scenario keeps each comparison's name distinct.
    // ------------------------------------------------------------------
    task automatic test_basic();
        axis.m_tready = 1'b1;
        start = 1'b1; pkt_len = 8'd4;
        step();
        start = 1'b0; pkt_len = 8'd0;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({axis.m_tvalid, axis.m_tdata, axis.m_tlast, busy} !== {1'b1, 8'(i), (i == 3), 1'b1})
                $display("FAIL basic_beat%0d: got v=%b d=%0d l=%b busy=%b expected v=1 d=%0d l=%b busy=1",
                         i, axis.m_tvalid, axis.m_tdata, axis.m_tlast, busy, i, (i == 3));
            else n_pass++;
            step();
        end
        n_checks++;
        if ({axis.m_tvalid, done, busy} !== 3'b011)
            $display("FAIL basic_done: got v=%b done=%b busy=%b expected 0 1 1",
                     axis.m_tvalid, done, busy);
        else n_pass++;
        step();
        n_checks++;
        if ({axis.m_tvalid, done, busy} !== 3'b001)
            $display("FAIL basic_gap: got v=%b done=%b busy=%b expected 0 0 1",
                     axis.m_tvalid, done, busy);
        else n_pass++;
        step();
        n_checks++;
        if ({axis.m_tvalid, done, busy} !== 3'b000)
            $display("FAIL basic_idle: got v=%b done=%b busy=%b expected 0 0 0",
                     axis.m_tvalid, done, busy);
        else n_pass++;
        exp_data = 8'd4;
        $display("packet len=4 complete");
    endtask

    // Start issued in the very first IDLE cycle; data continues from 4.
    task automatic test_back_to_back();
        start = 1'b1; pkt_len = 8'd2;
        step();
        start = 1'b0; pkt_len = 8'd0;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if ({axis.m_tvalid, axis.m_tdata, axis.m_tlast} !== {1'b1, exp_data, (i == 1)})
                $display("FAIL b2b_beat%0d: got v=%b d=%0d l=%b expected v=1 d=%0d l=%b",
                         i, axis.m_tvalid, axis.m_tdata, axis.m_tlast, exp_data, (i == 1));
            else n_pass++;
            exp_data = exp_data + 8'd1;
            step();
        end
        n_checks++;
        if ({axis.m_tvalid, done} !== 2'b01)
            $display("FAIL b2b_done: got v=%b done=%b expected 0 1", axis.m_tvalid, done);
        else n_pass++;
        step(); step();
        n_checks++;
        if (busy !== 1'b0)
            $display("FAIL b2b_busy_low: got %b expected 0", busy);
        else n_pass++;
        $display("packet len=2 complete");
    endtask

    // Ready pattern 1,0,0,1,0,1 against a 3-beat packet.
    task automatic test_backpressure();
        logic [5:0] pat;
        int beat;
        pat  = 6'b101001;
        beat = 0;
        start = 1'b1; pkt_len = 8'd3;
        step();
        start = 1'b0; pkt_len = 8'd0;
        for (int k = 0; k < 6; k++) begin
            axis.m_tready = pat[k];
            n_checks++;
            if ({axis.m_tvalid, axis.m_tdata, axis.m_tlast} !== {1'b1, exp_data + 8'(beat), (beat == 2)})
                $display("FAIL bp_cycle%0d: got v=%b d=%0d l=%b expected v=1 d=%0d l=%b",
                         k, axis.m_tvalid, axis.m_tdata, axis.m_tlast, exp_data + 8'(beat), (beat == 2));
            else n_pass++;
            step();
            if (pat[k]) beat++;
        end
        axis.m_tready = 1'b1;
        n_checks++;
        if ({axis.m_tvalid, done} !== 2'b01)
            $display("FAIL bp_done: got v=%b done=%b expected 0 1", axis.m_tvalid, done);
        else n_pass++;
        exp_data = exp_data + 8'd3;
        step(); step();
        $display("packet len=3 with backpressure complete");
    endtask

    task automatic test_ignore_start();
        axis.m_tready = 1'b0;
        start = 1'b1; pkt_len = 8'd3;
        step();
        // Stalled in SEND: this request and the new length must be ignored.
        start = 1'b1; pkt_len = 8'd5;
        step();
        start = 1'b0; pkt_len = 8'd0;
        axis.m_tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({axis.m_tvalid, axis.m_tdata, axis.m_tlast} !== {1'b1, exp_data, (i == 2)})
                $display("FAIL ign_beat%0d: got v=%b d=%0d l=%b expected v=1 d=%0d l=%b",
                         i, axis.m_tvalid, axis.m_tdata, axis.m_tlast, exp_data, (i == 2));
            else n_pass++;
            exp_data = exp_data + 8'd1;
            step();
        end
        n_checks++;
        if ({axis.m_tvalid, done} !== 2'b01)
            $display("FAIL ign_done: got v=%b done=%b expected 0 1", axis.m_tvalid, done);
        else n_pass++;
        // First gap cycle: request must not be queued.
        start = 1'b1; pkt_len = 8'd2;
        step();
        start = 1'b0; pkt_len = 8'd0;
        step();
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if ({axis.m_tvalid, busy} !== 2'b00)
                $display("FAIL ign_gap_start%0d: got v=%b busy=%b expected 0 0", i, axis.m_tvalid, busy);
            else n_pass++;
            step();
        end
        // Zero-length request.
        start = 1'b1; pkt_len = 8'd0;
        step();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if ({axis.m_tvalid, busy, done} !== 3'b000)
                $display("FAIL ign_len0_%0d: got v=%b busy=%b done=%b expected 0 0 0",
                         i, axis.m_tvalid, busy, done);
            else n_pass++;
            step();
        end
        $display("ignored-start scenarios complete");
    endtask

    // Long packet running the data counter through 255 -> 0.
    task automatic test_wrap();
        int len;
        len = 256 - int'(exp_data);
        start = 1'b1; pkt_len = 8'(len);
        step();
        start = 1'b0; pkt_len = 8'd0;
        for (int i = 0; i < len; i++) begin
            n_checks++;
            if ({axis.m_tvalid, axis.m_tdata, axis.m_tlast} !== {1'b1, exp_data, (i == len - 1)})
                $display("FAIL wrap_beat%0d: got v=%b d=%0d l=%b expected v=1 d=%0d l=%b",
                         i, axis.m_tvalid, axis.m_tdata, axis.m_tlast, exp_data, (i == len - 1));
            else n_pass++;
            exp_data = exp_data + 8'd1;
            step();
        end
        step(); step();
        start = 1'b1; pkt_len = 8'd2;
        step();
        start = 1'b0; pkt_len = 8'd0;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if ({axis.m_tvalid, axis.m_tdata, axis.m_tlast} !== {1'b1, 8'(i), (i == 1)})
                $display("FAIL wrap_after%0d: got v=%b d=%0d l=%b expected v=1 d=%0d l=%b",
                         i, axis.m_tvalid, axis.m_tdata, axis.m_tlast, i, (i == 1));
            else n_pass++;
            step();
        end
        exp_data = 8'd2;
        step(); step(); step();
        $display("wrap packets complete");
    endtask

    task automatic test_reset_mid_packet();
        axis.m_tready = 1'b1;
        start = 1'b1; pkt_len = 8'd5;
        step();
        start = 1'b0; pkt_len = 8'd0;
        step(); step();
        n_checks++;
        if (axis.m_tdata !== exp_data + 8'd2)
            $display("FAIL rstmid_beat2: got d=%0d expected %0d", axis.m_tdata, exp_data + 8'd2);
        else n_pass++;
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if ({axis.m_tvalid, axis.m_tdata, axis.m_tlast, busy, done} !== 12'h000)
            $display("FAIL rstmid_async: got v=%b d=%0d l=%b busy=%b done=%b expected all 0",
                     axis.m_tvalid, axis.m_tdata, axis.m_tlast, busy, done);
        else n_pass++;
        step(); step();
        rst = 1'b1;
        exp_data = 8'd0;
        step(); step();
        n_checks++;
        if ({axis.m_tvalid, busy} !== 2'b00)
            $display("FAIL rstmid_no_resume: got v=%b busy=%b expected 0 0", axis.m_tvalid, busy);
        else n_pass++;
        start = 1'b1; pkt_len = 8'd1;
        step();
        start = 1'b0; pkt_len = 8'd0;
        n_checks++;
        if ({axis.m_tvalid, axis.m_tdata, axis.m_tlast} !== {1'b1, 8'd0, 1'b1})
            $display("FAIL rstmid_single: got v=%b d=%0d l=%b expected v=1 d=0 l=1",
                     axis.m_tvalid, axis.m_tdata, axis.m_tlast);
        else n_pass++;
        step();
        n_checks++;
        if ({axis.m_tvalid, axis.m_tlast, done} !== 3'b001)
            $display("FAIL rstmid_single_done: got v=%b l=%b done=%b expected 0 0 1",
                     axis.m_tvalid, axis.m_tlast, done);
        else n_pass++;
        step(); step();
        $display("reset mid-packet scenario complete");
    endtask

    task automatic test_pkt_count();
`ifdef AXIS_SRC_PKT_CNT_EN
        // One packet already completed since the mid-packet reset.
        for (int p = 0; p < 2; p++) begin
            start = 1'b1; pkt_len = 8'd1;
            step();
            start = 1'b0; pkt_len = 8'd0;
            step(); step(); step();
        end
        n_checks++;
        if (pkt_count !== 16'd3)
            $display("FAIL pkt_count: got %0d expected 3", pkt_count);
        else n_pass++;
        $display("pkt_count scenario complete");
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_ignore_start();
        test_wrap();
        test_reset_mid_packet();
        test_pkt_count();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
